move_resolver: RTL and testbench

//  Parametrised successor board-update engine for an N x N Go board. Takes the current board and
//  one move, then places the stone and removes captured opponent groups via the shared group

---
 rtl/go_pkg.sv | 27 ++
 rtl/group_pruner.sv | 104 ++++++++++
 rtl/move_resolver.sv | 189 ++++++++++++++++++
 tb/tb_move_resolver.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/go_pkg.sv
// rtl/go_pkg.sv - Go board stone/status encodings and colour helpers
package go_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BLACK = 2'b01,
        WHITE = 2'b10
    } stone_t;

    typedef enum logic [1:0] {
        ST_OK        = 2'b00,
        ST_OFF_BOARD = 2'b01,
        ST_OCCUPIED  = 2'b10,
        ST_SUICIDE   = 2'b11
    } status_t;

    localparam int MAX_BOARD_N = 19;

    function automatic stone_t own_color(input logic turn);
        return turn ? WHITE : BLACK;
    endfunction

    function automatic stone_t opp_color(input logic turn);
        return turn ? BLACK : WHITE;
    endfunction

endpackage

// File: rtl/group_pruner.sv
// rtl/group_pruner.sv - removes every group of one colour that has no liberty
// Liberty-reachability grows one step per cycle until it stops changing.
module group_pruner
    import go_pkg::*;
#(
    parameter int BOARD_N = 9
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic                                  start_flag,
    input  logic [1:0]                            prune_color,
    input  logic [BOARD_N-1:0][BOARD_N-1:0][1:0]  board_in,
    output logic [BOARD_N-1:0][BOARD_N-1:0][1:0]  pruned_board,
    output logic                                  done_pulse
);

    typedef logic [BOARD_N-1:0][BOARD_N-1:0] mask_t;

    function automatic logic touches(input mask_t m, input int r, input int c);
        logic up, dn, lf, rt;
        up = (r > 0)         && m[(r > 0) ? r - 1 : r][c];
        dn = (r < BOARD_N-1) && m[(r < BOARD_N-1) ? r + 1 : r][c];
        lf = (c > 0)         && m[r][(c > 0) ? c - 1 : c];
        rt = (c < BOARD_N-1) && m[r][(c < BOARD_N-1) ? c + 1 : c];
        return up | dn | lf | rt;
    endfunction

    logic                                 busy_q, busy_d;
    logic                                 done_q, done_d;
    logic [1:0]                           color_q, color_d;
    logic [BOARD_N-1:0][BOARD_N-1:0][1:0] board_q, board_d;
    logic [BOARD_N-1:0][BOARD_N-1:0][1:0] pruned_q, pruned_d;
    mask_t                                alive_q, alive_d;
    mask_t                                in_color, in_empty, cur_color, seed, grown;

    always_comb begin
        for (int r = 0; r < BOARD_N; r++) begin
            for (int c = 0; c < BOARD_N; c++) begin
                in_color[r][c]  = (board_in[r][c] == prune_color);
                in_empty[r][c]  = (board_in[r][c] == EMPTY);
                cur_color[r][c] = (board_q[r][c] == color_q);
            end
        end
    end

    // Seed: stones touching an empty point. Grow: stones touching a live stone.
    always_comb begin
        for (int r = 0; r < BOARD_N; r++) begin
            for (int c = 0; c < BOARD_N; c++) begin
                seed[r][c]  = in_color[r][c] && touches(in_empty, r, c);
                grown[r][c] = alive_q[r][c] || (cur_color[r][c] && touches(alive_q, r, c));
            end
        end
    end

    always_comb begin
        busy_d   = busy_q;
        done_d   = 1'b0;
        color_d  = color_q;
        board_d  = board_q;
        alive_d  = alive_q;
        pruned_d = pruned_q;
        if (!busy_q && start_flag) begin
            busy_d  = 1'b1;
            color_d = prune_color;
            board_d = board_in;
            alive_d = seed;
        end else if (busy_q) begin
            if (grown == alive_q) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                for (int r = 0; r < BOARD_N; r++) begin
                    for (int c = 0; c < BOARD_N; c++) begin
                        pruned_d[r][c] = (cur_color[r][c] && !alive_q[r][c]) ? EMPTY : board_q[r][c];
                    end
                end
            end else begin
                alive_d = grown;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            color_q  <= '0;
            board_q  <= '0;
            alive_q  <= '0;
            pruned_q <= '0;
        end else begin
            busy_q   <= busy_d;
            done_q   <= done_d;
            color_q  <= color_d;
            board_q  <= board_d;
            alive_q  <= alive_d;
            pruned_q <= pruned_d;
        end
    end

    assign pruned_board = pruned_q;
    assign done_pulse   = done_q;

endmodule

// File: rtl/move_resolver.sv
// rtl/move_resolver.sv - applies one Go move: legality, placement, captures, suicide
module move_resolver
    import go_pkg::*;
#(
    parameter  int BOARD_N = 9,
    parameter  int COORD_W = 4,
    localparam int CAP_W   = $clog2(BOARD_N * BOARD_N + 1)
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic                                  start_flag,
    input  logic [BOARD_N-1:0][BOARD_N-1:0][1:0]  board_bus,
    input  logic                                  turn,
    input  logic                                  pass_in,
    input  logic [2*COORD_W-1:0]                  move_in,
    output logic [BOARD_N-1:0][BOARD_N-1:0][1:0]  next_board,
    output logic [CAP_W-1:0]                      captures,
    output logic [1:0]                            status,
    output logic                                  board_ready
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_LOAD     = 4'd1;
    localparam logic [3:0] S_CHECK    = 4'd2;
    localparam logic [3:0] S_PLACE    = 4'd3;
    localparam logic [3:0] S_OPP_GO   = 4'd4;
    localparam logic [3:0] S_OPP_WAIT = 4'd5;
    localparam logic [3:0] S_COUNT    = 4'd6;
    localparam logic [3:0] S_OWN_GO   = 4'd7;
    localparam logic [3:0] S_OWN_WAIT = 4'd8;
    localparam logic [3:0] S_JUDGE    = 4'd9;
    localparam logic [3:0] S_DONE     = 4'd10;

    logic [3:0]                           state_q, state_d;
    logic [BOARD_N-1:0][BOARD_N-1:0][1:0] work_q, work_d;
    logic [BOARD_N-1:0][BOARD_N-1:0][1:0] orig_q, orig_d;
    logic                                 turn_q, turn_d;
    logic [COORD_W-1:0]                   row_q, row_d, col_q, col_d;
    logic [1:0]                           res_status_q, res_status_d;
    logic [CAP_W-1:0]                     res_caps_q, res_caps_d;
    logic [BOARD_N-1:0][BOARD_N-1:0][1:0] next_board_q, next_board_d;
    logic [CAP_W-1:0]                     captures_q, captures_d;
    logic [1:0]                           status_q, status_d;
    logic                                 board_ready_q, board_ready_d;

    logic                                 prune_start, prune_done;
    logic [1:0]                           prune_color;
    logic [BOARD_N-1:0][BOARD_N-1:0][1:0] pruned;
    logic                                 in_range;
    logic [1:0]                           target_cell;
    logic [CAP_W-1:0]                     cap_cnt;

    group_pruner #(.BOARD_N(BOARD_N)) u_pruner (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .start_flag   (prune_start),
        .prune_color  (prune_color),
        .board_in     (work_q),
        .pruned_board (pruned),
        .done_pulse   (prune_done)
    );

    assign prune_start = (state_q == S_OPP_GO) || (state_q == S_OWN_GO);
    assign prune_color = (state_q == S_OWN_GO) ? own_color(turn_q) : opp_color(turn_q);
    assign in_range    = (int'(row_q) < BOARD_N) && (int'(col_q) < BOARD_N);

    always_comb begin
        target_cell = EMPTY;
        cap_cnt     = '0;
        for (int r = 0; r < BOARD_N; r++) begin
            for (int c = 0; c < BOARD_N; c++) begin
                if (int'(row_q) == r && int'(col_q) == c) begin
                    target_cell = work_q[r][c];
                end
                if (work_q[r][c] == opp_color(turn_q) && pruned[r][c] == EMPTY) begin
                    cap_cnt = cap_cnt + CAP_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        work_d        = work_q;
        orig_d        = orig_q;
        turn_d        = turn_q;
        row_d         = row_q;
        col_d         = col_q;
        res_status_d  = res_status_q;
        res_caps_d    = res_caps_q;
        next_board_d  = next_board_q;
        captures_d    = captures_q;
        status_d      = status_q;
        board_ready_d = 1'b0;
        case (state_q)
            S_IDLE: if (start_flag) state_d = S_LOAD;
            S_LOAD: begin
                work_d       = board_bus;
                orig_d       = board_bus;
                turn_d       = turn;
                row_d        = move_in[2*COORD_W-1:COORD_W];
                col_d        = move_in[COORD_W-1:0];
                res_status_d = ST_OK;
                res_caps_d   = '0;
                state_d      = pass_in ? S_DONE : S_CHECK;
            end
            S_CHECK: begin
                if (!in_range) begin
                    res_status_d = ST_OFF_BOARD;
                    state_d      = S_DONE;
                end else if (target_cell != EMPTY) begin
                    res_status_d = ST_OCCUPIED;
                    state_d      = S_DONE;
                end else begin
                    state_d = S_PLACE;
                end
            end
            S_PLACE: begin
                for (int r = 0; r < BOARD_N; r++) begin
                    for (int c = 0; c < BOARD_N; c++) begin
                        if (int'(row_q) == r && int'(col_q) == c) work_d[r][c] = own_color(turn_q);
                    end
                end
                state_d = S_OPP_GO;
            end
            S_OPP_GO:   state_d = S_OPP_WAIT;
            S_OPP_WAIT: if (prune_done) state_d = S_COUNT;
            S_COUNT: begin
                res_caps_d = cap_cnt;
                work_d     = pruned;
                state_d    = S_OWN_GO;
            end
            S_OWN_GO:   state_d = S_OWN_WAIT;
            S_OWN_WAIT: if (prune_done) state_d = S_JUDGE;
            // The own pass can only remove own stones, so any difference means suicide.
            S_JUDGE: begin
                if (pruned != work_q) begin
                    res_status_d = ST_SUICIDE;
                    res_caps_d   = '0;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                next_board_d  = (res_status_q == ST_OK) ? work_q : orig_q;
                captures_d    = (res_status_q == ST_OK) ? res_caps_q : '0;
                status_d      = res_status_q;
                board_ready_d = 1'b1;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= S_IDLE;
            work_q        <= '0;
            orig_q        <= '0;
            turn_q        <= 1'b0;
            row_q         <= '0;
            col_q         <= '0;
            res_status_q  <= ST_OK;
            res_caps_q    <= '0;
            next_board_q  <= '0;
            captures_q    <= '0;
            status_q      <= ST_OK;
            board_ready_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            work_q        <= work_d;
            orig_q        <= orig_d;
            turn_q        <= turn_d;
            row_q         <= row_d;
            col_q         <= col_d;
            res_status_q  <= res_status_d;
            res_caps_q    <= res_caps_d;
            next_board_q  <= next_board_d;
            captures_q    <= captures_d;
            status_q      <= status_d;
            board_ready_q <= board_ready_d;
        end
    end

    assign next_board  = next_board_q;
    assign captures    = captures_q;
    assign status      = status_q;
    assign board_ready = board_ready_q;

endmodule

// File: tb/tb_move_resolver.sv
// tb/tb_move_resolver.sv - randomized check of move_resolver against a Go rules model
module tb_move_resolver;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic trn, pss;
    logic st9, st13, st19;
    logic [8:0][8:0][1:0]   bb9, nb9;
    logic [12:0][12:0][1:0] bb13, nb13;
    logic [18:0][18:0][1:0] bb19, nb19;
    logic [7:0] mv9, mv13;
    logic [9:0] mv19;
    logic [6:0] cp9;
    logic [7:0] cp13;
    logic [8:0] cp19;
    logic [1:0] sts9, sts13, sts19;
    logic rd9, rd13, rd19;

    move_resolver #(.BOARD_N(9), .COORD_W(4)) dut9 (
        .clk_in(clk), .rst_in(rst), .start_flag(st9), .board_bus(bb9), .turn(trn),
        .pass_in(pss), .move_in(mv9), .next_board(nb9), .captures(cp9), .status(sts9),
        .board_ready(rd9));
    move_resolver #(.BOARD_N(13), .COORD_W(4)) dut13 (
        .clk_in(clk), .rst_in(rst), .start_flag(st13), .board_bus(bb13), .turn(trn),
        .pass_in(pss), .move_in(mv13), .next_board(nb13), .captures(cp13), .status(sts13),
        .board_ready(rd13));
    move_resolver #(.BOARD_N(19), .COORD_W(5)) dut19 (
        .clk_in(clk), .rst_in(rst), .start_flag(st19), .board_bus(bb19), .turn(trn),
        .pass_in(pss), .move_in(mv19), .next_board(nb19), .captures(cp19), .status(sts19),
        .board_ready(rd19));

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    int mb[19][19];
    int eb[19][19];
    int vis[19][19];
    int grp[$];
    int exp_caps, exp_status;

    function automatic void clear_vis();
        for (int r = 0; r < 19; r++) for (int c = 0; c < 19; c++) vis[r][c] = 0;
    endfunction

    // Breadth-first walk of the group at (r0,c0) on eb; returns 1 if it has a liberty.
    function automatic bit flood(input int n, input int r0, input int c0);
        int color, idx, cr, cc, nr, nc;
        bit libs;
        int dr[4] = '{-1, 1, 0, 0};
        int dc[4] = '{0, 0, -1, 1};
        color = eb[r0][c0];
        grp.delete();
        grp.push_back(r0 * 19 + c0);
        vis[r0][c0] = 1;
        libs = 0;
        idx = 0;
        while (idx < grp.size()) begin
            cr = grp[idx] / 19;
            cc = grp[idx] % 19;
            idx++;
            for (int d = 0; d < 4; d++) begin
                nr = cr + dr[d];
                nc = cc + dc[d];
                if (nr >= 0 && nr < n && nc >= 0 && nc < n) begin
                    if (eb[nr][nc] == 0) libs = 1;
                    else if (eb[nr][nc] == color && vis[nr][nc] == 0) begin
                        vis[nr][nc] = 1;
                        grp.push_back(nr * 19 + nc);
                    end
                end
            end
        end
        return libs;
    endfunction

    function automatic void ref_move(input int n, input bit p, input bit t, input int r, input int c);
        int own, opp;
        own = t ? 2 : 1;
        opp = t ? 1 : 2;
        eb = mb;
        exp_caps = 0;
        exp_status = 0;
        if (p) return;
        if (r >= n || c >= n) begin exp_status = 1; return; end
        if (mb[r][c] != 0) begin exp_status = 2; return; end
        eb[r][c] = own;
        clear_vis();
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++)
                if (eb[i][j] == opp && vis[i][j] == 0 && !flood(n, i, j))
                    foreach (grp[k]) begin
                        eb[grp[k] / 19][grp[k] % 19] = 0;
                        exp_caps++;
                    end
        clear_vis();
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++)
                if (eb[i][j] == own && vis[i][j] == 0 && !flood(n, i, j)) exp_status = 3;
        if (exp_status == 3) begin
            exp_caps = 0;
            eb = mb;
        end
    endfunction

    function automatic int nsize(input int w);
        return (w == 0) ? 9 : (w == 1) ? 13 : 19;
    endfunction

    function automatic int get_cell(input int w, input int r, input int c);
        case (w)
            0:       return int'(nb9[r][c]);
            1:       return int'(nb13[r][c]);
            default: return int'(nb19[r][c]);
        endcase
    endfunction

    function automatic int get_ready(input int w);
        return (w == 0) ? int'(rd9) : (w == 1) ? int'(rd13) : int'(rd19);
    endfunction

    function automatic int get_status(input int w);
        return (w == 0) ? int'(sts9) : (w == 1) ? int'(sts13) : int'(sts19);
    endfunction

    function automatic int get_caps(input int w);
        return (w == 0) ? int'(cp9) : (w == 1) ? int'(cp13) : int'(cp19);
    endfunction

    task automatic set_start(input int w, input logic v);
        case (w)
            0:       st9 = v;
            1:       st13 = v;
            default: st19 = v;
        endcase
    endtask

    task automatic drive(input int w, input int r, input int c);
        for (int i = 0; i < nsize(w); i++)
            for (int j = 0; j < nsize(w); j++)
                case (w)
                    0:       bb9[i][j] = 2'(mb[i][j]);
                    1:       bb13[i][j] = 2'(mb[i][j]);
                    default: bb19[i][j] = 2'(mb[i][j]);
                endcase
        case (w)
            0:       mv9 = {4'(r), 4'(c)};
            1:       mv13 = {4'(r), 4'(c)};
            default: mv19 = {5'(r), 5'(c)};
        endcase
    endtask

    task automatic scramble(input int w);
        case (w)
            0:       begin bb9 = ~bb9; mv9 = ~mv9; end
            1:       begin bb13 = ~bb13; mv13 = ~mv13; end
            default: begin bb19 = ~bb19; mv19 = ~mv19; end
        endcase
        trn = ~trn;
        pss = ~pss;
    endtask

    function automatic int board_diff(input int w);
        int cnt = 0;
        for (int i = 0; i < nsize(w); i++)
            for (int j = 0; j < nsize(w); j++)
                if (get_cell(w, i, j) != eb[i][j]) cnt++;
        return cnt;
    endfunction

    function automatic int board_nonempty(input int w);
        int cnt = 0;
        for (int i = 0; i < nsize(w); i++)
            for (int j = 0; j < nsize(w); j++)
                if (get_cell(w, i, j) != 0) cnt++;
        return cnt;
    endfunction

    task automatic clear_board();
        for (int i = 0; i < 19; i++) for (int j = 0; j < 19; j++) mb[i][j] = 0;
    endtask

    task automatic rand_board(input int n);
        int x;
        clear_board();
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++) begin
                x = $urandom_range(0, 9);
                mb[i][j] = (x < 5) ? 0 : (x < 7) ? 1 : 2;
            end
    endtask

    task automatic do_move(input string tag, input int w, input bit p, input bit t,
                           input int r, input int c, input int want_lat);
        int lat;
        int got;
        ref_move(nsize(w), p, t, r, c);
        @(negedge clk);
        drive(w, r, c);
        trn = t;
        pss = p;
        set_start(w, 1'b1);
        lat = 0;
        got = 0;
        while (got == 0 && lat < 3000) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) set_start(w, 1'b0);
            if (lat == 2) begin
                scramble(w);
                set_start(w, 1'b1);
            end
            if (lat == 3) set_start(w, 1'b0);
            got = get_ready(w);
        end
        set_start(w, 1'b0);
        check({tag, "_ready"}, got, 1);
        if (want_lat > 0) check({tag, "_latency"}, lat, want_lat);
        check({tag, "_status"}, get_status(w), exp_status);
        check({tag, "_captures"}, get_caps(w), exp_caps);
        check({tag, "_board_diff"}, board_diff(w), 0);
        @(posedge clk);
        #1;
        check({tag, "_ready_drop"}, get_ready(w), 0);
    endtask

    initial begin
        int pulses, n, mode, r, c, tries, lim;
        string nm[3] = '{"n9", "n13", "n19"};
        rst = 1'b1;
        trn = 0; pss = 0; st9 = 0; st13 = 0; st19 = 0;
        bb9 = '0; bb13 = '0; bb19 = '0; mv9 = '0; mv13 = '0; mv19 = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int w = 0; w < 3; w++) begin
            check({nm[w], "_rst_board"}, board_nonempty(w), 0);
            check({nm[w], "_rst_status"}, get_status(w), 0);
            check({nm[w], "_rst_caps"}, get_caps(w), 0);
            check({nm[w], "_rst_ready"}, get_ready(w), 0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int w = 0; w < 3; w++) begin
            clear_board();
            do_move({nm[w], "_t1"}, w, 0, 0, 4, 4, 0);
            check({nm[w], "_t1_cell"}, get_cell(w, 4, 4), 1);
            clear_board();
            mb[0][0] = 2;
            mb[0][1] = 1;
            do_move({nm[w], "_t2"}, w, 0, 0, 1, 0, 0);
            check({nm[w], "_t2_caps"}, get_caps(w), 1);
            check({nm[w], "_t2_cell"}, get_cell(w, 0, 0), 0);
        end

        clear_board();
        mb[2][2] = 2;
        do_move("t3_occupied", 0, 0, 0, 2, 2, 4);
        check("t3_status", get_status(0), 2);
        do_move("t4_offboard", 0, 0, 1, 9, 3, 4);
        check("t4_status", get_status(0), 1);
        rand_board(9);
        do_move("pass", 0, 1, 1, 3, 3, 3);

        clear_board();
        mb[0][1] = 2; mb[1][0] = 2; mb[1][1] = 2;
        do_move("t5_suicide", 0, 0, 0, 0, 0, 0);
        check("t5_suicide_status", get_status(0), 3);
        clear_board();
        mb[0][1] = 2; mb[1][0] = 2; mb[0][2] = 1; mb[1][1] = 1; mb[2][0] = 1;
        do_move("t5_capture", 0, 0, 0, 0, 0, 0);
        check("t5_capture_caps", get_caps(0), 2);

        clear_board();
        @(negedge clk);
        drive(0, 2, 2);
        trn = 0;
        pss = 0;
        st9 = 1'b1;
        @(posedge clk);
        #1;
        st9 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t6_rst_board", board_nonempty(0), 0);
        check("t6_rst_status", get_status(0), 0);
        check("t6_rst_caps", get_caps(0), 0);
        check("t6_rst_ready", get_ready(0), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (rd9) pulses++;
        end
        check("t6_no_pulse", pulses, 0);
        clear_board();
        do_move("t6_after", 0, 0, 0, 4, 4, 0);

        for (int k = 0; k < 70; k++) begin
            int w;
            w = (k < 40) ? 0 : (k < 55) ? 1 : 2;
            n = nsize(w);
            lim = (w == 2) ? 31 : 15;
            rand_board(n);
            mode = $urandom_range(0, 19);
            r = $urandom_range(0, n - 1);
            c = $urandom_range(0, n - 1);
            if (mode == 1) r = $urandom_range(n, lim);
            else if (mode == 2) c = $urandom_range(n, lim);
            else if (mode > 6) begin
                tries = 0;
                while (mb[r][c] != 0 && tries < 50) begin
                    r = $urandom_range(0, n - 1);
                    c = $urandom_range(0, n - 1);
                    tries++;
                end
            end
            do_move($sformatf("rnd%0d_%s", k, nm[w]), w, (mode == 0), 1'($urandom_range(0, 1)),
                    r, c, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
